alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Consumes one ALU result per transaction: 32-bit result, 4-bit op code, destination register.
- Drives the single-port register-file write interface.
- Single-result ops (add, sub, and, or, unsigned add) take one write to the destination.
- Two-result ops (mult, div) take two writes: low half to the destination, then high half (product high word or remainder) to a fixed HI register. A valid/ready handshake stalls the ALU stage while the second write is in flight.

Parameters:
- DATA_W, 16, register width; result input is 2*DATA_W.
- ADDR_W, 4, register address width.
- HI_REG, 15, register receiving the high half of mult/div.
- ZERO_RO, 1, when 1 any write to register 0 is suppressed (rf_we stays low; flags still produced).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  ALU result valid.
- in_ready  output  1  block can accept this cycle.
- in_ctrl  input  4  ALU op code: 0 add, 1 sub, 2 mult, 3 div, 4 and, 5 or, 6 unsigned add.
- in_result  input  32  ALU result; for div, {remainder, quotient}.
- in_dest  input  ADDR_W  destination register.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  ADDR_W  write address.
- rf_wdata  output  DATA_W  write data.
- flag_valid  output  1  one-cycle pulse, flags below valid.
- flag_zero  output  1  low half == 0.
- flag_neg  output  1  low half bit 15.
- flag_ovf  output  1  overflow/carry, per Behaviour.

Behaviour:
- Reset (async, immediate): state IDLE; rf_we=0, rf_waddr=0, rf_wdata=0; all flag outputs 0; hi_pending=0.
- Transfer occurs on a rising edge with in_valid && in_ready. The transfer captures ctrl, result and dest.
- in_ready is combinational: 0 only when state==WR_LO && hi_pending; 1 otherwise, including during reset release.
- States and transitions:
  - IDLE: transfer -> WR_LO; else stay.
  - WR_LO: hi_pending -> WR_HI; else transfer -> WR_LO (back-to-back); else -> IDLE.
  - WR_HI: transfer -> WR_LO; else -> IDLE.
- All rf_* and flag_* outputs are registered.
- WR_LO cycle: rf_we=1, rf_waddr=dest, rf_wdata=result[15:0]; flag_valid=1.
- WR_HI cycle: rf_we=1, rf_waddr=HI_REG, rf_wdata=result[31:16]; flag_valid=0; flags hold.
- hi_pending=1 for ctrl 2 or 3, else 0.
- Latency:
  - Low write is visible the cycle after the transfer edge.
  - High write follows one cycle after the low write.
  - Sustained throughput: 1 op/cycle for single-write ops; 2 cycles/op for mult/div.
- Flag rules (from captured data):
  - flag_zero = (result[15:0]==0).
  - flag_neg = result[15].
  - flag_ovf for ctrl 0/1: result[31:15] is not all-equal (signed 16-bit overflow).
  - flag_ovf for ctrl 6: result[16] (carry).
  - flag_ovf for ctrl 2/3/4/5: 0.
- Undefined ctrl (7..15):
  - The transaction is accepted and produces no writes, so rf_we stays 0.
  - flag_valid pulses once with all flags 0.
  - State passes through WR_LO with the write suppressed.
- ZERO_RO with dest 0: low write suppressed, flags pulse normally. For mult/div the HI write still occurs.
- When no write is occurring, rf_we=0; rf_waddr and rf_wdata hold their last values.
- Reset mid-transaction, including during WR_HI: the pending high write is discarded, with no partial write after reset release.

Decomposition:
- Shared package cpu_pkg:
  - ALU op-code constants (OP_ADD=0 .. OP_UADD=6).
  - Default DATA_W/ADDR_W.
  - HI_REG default.
  - wb_state enum {IDLE, WR_LO, WR_HI}.
- One natural sub-module, wb_flag_gen: combinational flag computation from ctrl and the 32-bit result. It is also reused by a future branch unit.

Test Plan:
1. Add: ctrl=0, result=0x0000_0007, dest=3 -> next cycle rf_we=1, waddr=3, wdata=0x0007; zero=0, neg=0, ovf=0; in_ready stays 1.
2. Signed overflow: ctrl=0, result=0x0000_8000 (A=0x7FFF, B=1), dest=2 -> wdata=0x8000, neg=1, ovf=1. Unsigned add: ctrl=6, result=0x0001_0000 -> wdata=0x0000, zero=1, ovf=1.
3. Div: ctrl=3, result={0x0001,0x0003} (7/2), dest=4:
   - Cycle 1: write reg4=0x0003, with in_ready=0 during this cycle.
   - Cycle 2: write reg15=0x0001.
   - A second valid op held during the stall is accepted in cycle 2 and written in cycle 3.
4. Back-to-back: four single ops on consecutive cycles with valid held high -> four consecutive rf_we pulses, addresses and data in order, no bubbles.
5. ZERO_RO / undefined: ctrl=0, dest=0 -> no rf_we, flag_valid pulses. ctrl=9 -> no rf_we, flags all 0.
6. Reset mid-op: assert rst asynchronously while in WR_HI after a mult -> outputs 0 immediately; after release there is no write to reg15, and in_ready=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op codes, default widths and the writeback FSM state type.
package cpu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int HI_REG_DEF = 15;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MULT = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_UADD = 4'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wb_state_e;

  function automatic logic op_is_defined(input logic [3:0] ctrl);
    return (ctrl <= OP_UADD);
  endfunction

  // mult/div carry a second result half that needs its own register-file write.
  function automatic logic op_is_two_write(input logic [3:0] ctrl);
    return (ctrl == OP_MULT) || (ctrl == OP_DIV);
  endfunction

endpackage

// File: rtl/wb_flag_gen.sv
// Combinational condition flags for a 2*DATA_W ALU result; undefined op codes give all-zero flags.
module wb_flag_gen
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [3:0]          ctrl_i,
  input  logic [2*DATA_W-1:0] result_i,
  output logic                zero_o,
  output logic                neg_o,
  output logic                ovf_o
);

  logic [DATA_W:0] sign_ext;
  logic            defined;

  assign defined  = op_is_defined(ctrl_i);
  // A signed low-half result is exact only if everything above it replicates its sign bit.
  assign sign_ext = result_i[2*DATA_W-1:DATA_W-1];

  always_comb begin
    zero_o = 1'b0;
    neg_o  = 1'b0;
    ovf_o  = 1'b0;
    if (defined) begin
      zero_o = (result_i[DATA_W-1:0] == '0);
      neg_o  = result_i[DATA_W-1];
      case (ctrl_i)
        OP_ADD, OP_SUB: ovf_o = !((&sign_ext) || !(|sign_ext));
        OP_UADD:        ovf_o = result_i[DATA_W];
        default:        ovf_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: turns each ALU result into one or two register-file writes plus flags,
// stalling the ALU via in_ready while a mult/div high-half write is outstanding.
module alu_writeback
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int HI_REG  = HI_REG_DEF,
  parameter bit ZERO_RO = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_ctrl,
  input  logic [2*DATA_W-1:0] in_result,
  input  logic [ADDR_W-1:0]   in_dest,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                flag_valid,
  output logic                flag_zero,
  output logic                flag_neg,
  output logic                flag_ovf
);

  wb_state_e           state_q, state_d;
  logic                hi_pending_q, hi_pending_d;
  logic [DATA_W-1:0]   result_hi_q, result_hi_d;
  logic                rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic                flag_valid_q, flag_valid_d;
  logic                flag_zero_q, flag_zero_d;
  logic                flag_neg_q, flag_neg_d;
  logic                flag_ovf_q, flag_ovf_d;

  logic                transfer;
  logic                gen_zero, gen_neg, gen_ovf;
  logic                lo_write_en;

  wb_flag_gen #(
    .DATA_W(DATA_W)
  ) u_flag_gen (
    .ctrl_i  (in_ctrl),
    .result_i(in_result),
    .zero_o  (gen_zero),
    .neg_o   (gen_neg),
    .ovf_o   (gen_ovf)
  );

  assign in_ready    = !((state_q == WR_LO) && hi_pending_q);
  assign transfer    = in_valid && in_ready;
  assign lo_write_en = op_is_defined(in_ctrl) && !(ZERO_RO && (in_dest == '0));

  always_comb begin
    state_d      = state_q;
    hi_pending_d = hi_pending_q;
    result_hi_d  = result_hi_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    flag_valid_d = 1'b0;
    flag_zero_d  = flag_zero_q;
    flag_neg_d   = flag_neg_q;
    flag_ovf_d   = flag_ovf_q;

    if ((state_q == WR_LO) && hi_pending_q) begin
      state_d      = WR_HI;
      hi_pending_d = 1'b0;
      rf_we_d      = 1'b1;
      rf_waddr_d   = ADDR_W'(HI_REG);
      rf_wdata_d   = result_hi_q;
    end else if (transfer) begin
      // Every accepted op passes through WR_LO, even when its low write is suppressed.
      state_d      = WR_LO;
      hi_pending_d = op_is_two_write(in_ctrl);
      result_hi_d  = in_result[2*DATA_W-1:DATA_W];
      flag_valid_d = 1'b1;
      flag_zero_d  = gen_zero;
      flag_neg_d   = gen_neg;
      flag_ovf_d   = gen_ovf;
      if (lo_write_en) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = in_dest;
        rf_wdata_d = in_result[DATA_W-1:0];
      end
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      hi_pending_q <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      flag_valid_q <= 1'b0;
      flag_zero_q  <= 1'b0;
      flag_neg_q   <= 1'b0;
      flag_ovf_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_pending_q <= hi_pending_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      flag_valid_q <= flag_valid_d;
      flag_zero_q  <= flag_zero_d;
      flag_neg_q   <= flag_neg_d;
      flag_ovf_q   <= flag_ovf_d;
    end
  end

  // High-half data is only consumed behind hi_pending_q, so it needs no reset.
  always_ff @(posedge clk) begin
    result_hi_q <= result_hi_d;
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign flag_valid = flag_valid_q;
  assign flag_zero  = flag_zero_q;
  assign flag_neg   = flag_neg_q;
  assign flag_ovf   = flag_ovf_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback with hand-computed expectations.
module tb_alu_writeback;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_ctrl;
  logic [31:0] in_result;
  logic [3:0]  in_dest;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        flag_valid;
  logic        flag_zero;
  logic        flag_neg;
  logic        flag_ovf;

  int tests = 0;
  int fails = 0;

  alu_writeback dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_result (in_result),
    .in_dest   (in_dest),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .flag_valid(flag_valid),
    .flag_zero (flag_zero),
    .flag_neg  (flag_neg),
    .flag_ovf  (flag_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_ctrl = 4'd0; in_result = 32'd0; in_dest = 4'd0;
    #3;
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %0b required 0", rf_we); end
    tests++; if (rf_waddr !== 4'd0 || rf_wdata !== 16'd0) begin fails++; $display("FAIL reset_addr_data: got %0h/%0h required 0/0", rf_waddr, rf_wdata); end
    tests++; if ({flag_valid, flag_zero, flag_neg, flag_ovf} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b required 0000", {flag_valid, flag_zero, flag_neg, flag_ovf}); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b required 1", in_ready); end
    tick();
    rst = 1'b0;
    tick();
    tests++; if (rf_we !== 1'b0 || flag_valid !== 1'b0) begin fails++; $display("FAIL idle_quiet: got we=%0b fv=%0b required 0/0", rf_we, flag_valid); end
  endtask

  task automatic test_add();
    in_valid = 1'b1; in_ctrl = 4'd0; in_result = 32'h0000_0007; in_dest = 4'd3;
    tick();
    in_valid = 1'b0;
    tests++; if (rf_we !== 1'b1 || rf_waddr !== 4'd3 || rf_wdata !== 16'h0007) begin fails++; $display("FAIL add_write: got we=%0b a=%0d d=%h required 1/3/0007", rf_we, rf_waddr, rf_wdata); end
    tests++; if ({flag_valid, flag_zero, flag_neg, flag_ovf} !== 4'b1000) begin fails++; $display("FAIL add_flags: got %b required 1000", {flag_valid, flag_zero, flag_neg, flag_ovf}); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL add_ready: got %0b required 1", in_ready); end
    tick();
    tests++; if (rf_we !== 1'b0 || flag_valid !== 1'b0 || rf_waddr !== 4'd3 || rf_wdata !== 16'h0007) begin fails++; $display("FAIL add_hold: got we=%0b fv=%0b a=%0d d=%h required 0/0/3/0007", rf_we, flag_valid, rf_waddr, rf_wdata); end
  endtask

  task automatic test_overflow();
    in_valid = 1'b1; in_ctrl = 4'd0; in_result = 32'h0000_8000; in_dest = 4'd2;
    tick();
    in_valid = 1'b0;
    tests++; if (rf_we !== 1'b1 || rf_waddr !== 4'd2 || rf_wdata !== 16'h8000) begin fails++; $display("FAIL sovf_write: got we=%0b a=%0d d=%h required 1/2/8000", rf_we, rf_waddr, rf_wdata); end
    tests++; if ({flag_valid, flag_zero, flag_neg, flag_ovf} !== 4'b1011) begin fails++; $display("FAIL sovf_flags: got %b required 1011", {flag_valid, flag_zero, flag_neg, flag_ovf}); end
    tick();
    in_valid = 1'b1; in_ctrl = 4'd6; in_result = 32'h0001_0000; in_dest = 4'd5;
    tick();
    in_valid = 1'b0;
    tests++; if (rf_we !== 1'b1 || rf_waddr !== 4'd5 || rf_wdata !== 16'h0000) begin fails++; $display("FAIL uadd_write: got we=%0b a=%0d d=%h required 1/5/0000", rf_we, rf_waddr, rf_wdata); end
    tests++; if ({flag_valid, flag_zero, flag_neg, flag_ovf} !== 4'b1101) begin fails++; $display("FAIL uadd_flags: got %b required 1101", {flag_valid, flag_zero, flag_neg, flag_ovf}); end
    tick();
    // Subtract result that sign-extends cleanly: no overflow despite the set upper bits.
    in_valid = 1'b1; in_ctrl = 4'd1; in_result = 32'hFFFF_FFFE; in_dest = 4'd1;
    tick();
    in_valid = 1'b0;
    tests++; if (rf_wdata !== 16'hFFFE || {flag_valid, flag_zero, flag_neg, flag_ovf} !== 4'b1010) begin fails++; $display("FAIL sub_neg: got d=%h flags=%b required FFFE/1010", rf_wdata, {flag_valid, flag_zero, flag_neg, flag_ovf}); end
    tick();
  endtask

  task automatic test_div_stall();
    in_valid = 1'b1; in_ctrl = 4'd3; in_result = 32'h0001_0003; in_dest = 4'd4;
    tick();
    in_ctrl = 4'd1; in_result = 32'h0000_0005; in_dest = 4'd6;
    tests++; if (rf_we !== 1'b1 || rf_waddr !== 4'd4 || rf_wdata !== 16'h0003) begin fails++; $display("FAIL div_lo: got we=%0b a=%0d d=%h required 1/4/0003", rf_we, rf_waddr, rf_wdata); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL div_stall: got ready=%0b required 0", in_ready); end
    tests++; if ({flag_valid, flag_zero, flag_neg, flag_ovf} !== 4'b1000) begin fails++; $display("FAIL div_flags: got %b required 1000", {flag_valid, flag_zero, flag_neg, flag_ovf}); end
    tick();
    tests++; if (rf_we !== 1'b1 || rf_waddr !== 4'd15 || rf_wdata !== 16'h0001) begin fails++; $display("FAIL div_hi: got we=%0b a=%0d d=%h required 1/15/0001", rf_we, rf_waddr, rf_wdata); end
    tests++; if (flag_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL div_hi_ctl: got fv=%0b ready=%0b required 0/1", flag_valid, in_ready); end
    tick();
    in_valid = 1'b0;
    tests++; if (rf_we !== 1'b1 || rf_waddr !== 4'd6 || rf_wdata !== 16'h0005 || flag_valid !== 1'b1) begin fails++; $display("FAIL div_next: got we=%0b a=%0d d=%h fv=%0b required 1/6/0005/1", rf_we, rf_waddr, rf_wdata, flag_valid); end
    tick();
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL div_drain: got we=%0b required 0", rf_we); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  c [4] = '{4'd0, 4'd1, 4'd4, 4'd5};
    logic [31:0] r [4] = '{32'h0000_0011, 32'hFFFF_FFFF, 32'h0000_00F0, 32'h0000_0F00};
    logic [3:0]  d [4] = '{4'd1, 4'd7, 4'd8, 4'd9};
    logic [3:0]  f [4] = '{4'b1000, 4'b1010, 4'b1000, 4'b1000};
    in_valid = 1'b1; in_ctrl = c[0]; in_result = r[0]; in_dest = d[0];
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (rf_we !== 1'b1 || rf_waddr !== d[i] || rf_wdata !== r[i][15:0] || in_ready !== 1'b1 ||
          {flag_valid, flag_zero, flag_neg, flag_ovf} !== f[i]) begin
        fails++;
        $display("FAIL b2b_%0d: got we=%0b a=%0d d=%h rdy=%0b fl=%b required 1/%0d/%h/1/%b",
                 i, rf_we, rf_waddr, rf_wdata, in_ready, {flag_valid, flag_zero, flag_neg, flag_ovf},
                 d[i], r[i][15:0], f[i]);
      end
      if (i < 3) begin
        in_ctrl = c[i+1]; in_result = r[i+1]; in_dest = d[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    tick();
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL b2b_end: got we=%0b required 0", rf_we); end
  endtask

  task automatic test_zero_ro_undef();
    in_valid = 1'b1; in_ctrl = 4'd0; in_result = 32'h0000_0000; in_dest = 4'd0;
    tick();
    in_valid = 1'b0;
    tests++; if (rf_we !== 1'b0 || rf_waddr !== 4'd9 || rf_wdata !== 16'h0F00) begin fails++; $display("FAIL zro_write: got we=%0b a=%0d d=%h required 0/9/0F00", rf_we, rf_waddr, rf_wdata); end
    tests++; if ({flag_valid, flag_zero, flag_neg, flag_ovf} !== 4'b1100) begin fails++; $display("FAIL zro_flags: got %b required 1100", {flag_valid, flag_zero, flag_neg, flag_ovf}); end
    tick();
    in_valid = 1'b1; in_ctrl = 4'd9; in_result = 32'hFFFF_8000; in_dest = 4'd3;
    tick();
    in_valid = 1'b0;
    tests++; if (rf_we !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL undef_write: got we=%0b rdy=%0b required 0/1", rf_we, in_ready); end
    tests++; if ({flag_valid, flag_zero, flag_neg, flag_ovf} !== 4'b1000) begin fails++; $display("FAIL undef_flags: got %b required 1000", {flag_valid, flag_zero, flag_neg, flag_ovf}); end
    tick();
    tests++; if (rf_we !== 1'b0 || flag_valid !== 1'b0) begin fails++; $display("FAIL undef_after: got we=%0b fv=%0b required 0/0", rf_we, flag_valid); end
    in_valid = 1'b1; in_ctrl = 4'd2; in_result = 32'h0002_0000; in_dest = 4'd0;
    tick();
    in_valid = 1'b0;
    tests++; if (rf_we !== 1'b0 || flag_valid !== 1'b1 || flag_zero !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL zro_mult_lo: got we=%0b fv=%0b z=%0b rdy=%0b required 0/1/1/0", rf_we, flag_valid, flag_zero, in_ready); end
    tick();
    tests++; if (rf_we !== 1'b1 || rf_waddr !== 4'd15 || rf_wdata !== 16'h0002) begin fails++; $display("FAIL zro_mult_hi: got we=%0b a=%0d d=%h required 1/15/0002", rf_we, rf_waddr, rf_wdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    // Reset while the high write is still pending (low-write cycle).
    in_valid = 1'b1; in_ctrl = 4'd2; in_result = 32'hABCD_1111; in_dest = 4'd5;
    tick();
    in_valid = 1'b0;
    tests++; if (rf_we !== 1'b1 || rf_waddr !== 4'd5 || in_ready !== 1'b0) begin fails++; $display("FAIL rlo_pre: got we=%0b a=%0d rdy=%0b required 1/5/0", rf_we, rf_waddr, in_ready); end
    #2 rst = 1'b1;
    #1;
    tests++; if (rf_we !== 1'b0 || rf_waddr !== 4'd0 || rf_wdata !== 16'd0 || flag_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL rlo_async: got we=%0b a=%0d d=%h fv=%0b rdy=%0b required 0/0/0000/0/1", rf_we, rf_waddr, rf_wdata, flag_valid, in_ready); end
    tick();
    rst = 1'b0;
    tick();
    tests++; if (rf_we !== 1'b0 || rf_waddr !== 4'd0) begin fails++; $display("FAIL rlo_nohi: got we=%0b a=%0d required 0/0", rf_we, rf_waddr); end
    // Reset during the high-write cycle itself.
    in_valid = 1'b1; in_ctrl = 4'd2; in_result = 32'h1234_5678; in_dest = 4'd5;
    tick();
    in_valid = 1'b0;
    tick();
    tests++; if (rf_we !== 1'b1 || rf_waddr !== 4'd15 || rf_wdata !== 16'h1234) begin fails++; $display("FAIL rhi_pre: got we=%0b a=%0d d=%h required 1/15/1234", rf_we, rf_waddr, rf_wdata); end
    #2 rst = 1'b1;
    #1;
    tests++; if (rf_we !== 1'b0 || rf_waddr !== 4'd0 || rf_wdata !== 16'd0 || {flag_zero, flag_neg, flag_ovf} !== 3'b000) begin fails++; $display("FAIL rhi_async: got we=%0b a=%0d d=%h fl=%b required 0/0/0000/000", rf_we, rf_waddr, rf_wdata, {flag_zero, flag_neg, flag_ovf}); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (rf_we !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL rhi_after_%0d: got we=%0b rdy=%0b required 0/1", i, rf_we, in_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_div_stall();
    test_back_to_back();
    test_zero_ro_undef();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
